// File: rtl/pipe_mem_pkg.sv
// rtl/pipe_mem_pkg.sv - shared states, constants and address helper for pipe_mem_responder
package pipe_mem_pkg;

  typedef enum logic [1:0] {CLEAR, LOAD, RUN} state_t;

  localparam int unsigned WORD_BYTES    = 4;
  localparam logic [31:0] NOP_WORD      = 32'h0;
  localparam logic [5:0]  FINISH_OPCODE = 6'b111111;

  function automatic int unsigned word_index(input int unsigned byte_addr);
    return byte_addr / WORD_BYTES;
  endfunction

endpackage

// File: rtl/pipe_mem_bank.sv
// rtl/pipe_mem_bank.sv - DEPTH x DATA_W array, one write port, one registered read port
// PIPE_MEM_WR_BYPASS_EN selects write-first on a same-index read/write; default is read-first.
module pipe_mem_bank #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_rd_en,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  import pipe_mem_pkg::*;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Array has no reset so it maps onto plain RAM; contents survive rst.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= DATA_W'(NOP_WORD);
    end else if (!i_rd_en) begin
      r_rdata <= DATA_W'(NOP_WORD);
    end else begin
`ifdef PIPE_MEM_WR_BYPASS_EN
      if (i_we && (i_waddr == i_raddr)) r_rdata <= i_wdata;
      else                              r_rdata <= r_mem[i_raddr];
`else
      r_rdata <= r_mem[i_raddr];
`endif
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/pipe_mem_responder.sv
// rtl/pipe_mem_responder.sv - imem/dmem responder with clear/load/run sequencing
// PIPE_MEM_WR_BYPASS_EN (in pipe_mem_bank) makes same-word dmem read/write return the new word.
module pipe_mem_responder #(
  parameter int                ADDR_W    = 10,
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 256,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] RAddr_i,
  output logic [DATA_W-1:0] Rdata_i,
  input  logic [ADDR_W-1:0] RAddr_d,
  output logic [DATA_W-1:0] Rdata_d,
  input  logic              Wen,
  input  logic [ADDR_W-1:0] WAddr_d,
  input  logic [DATA_W-1:0] Wdata_d,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_done,
  output logic              busy,
  output logic              misalign
);
  import pipe_mem_pkg::*;

  localparam int IDX_W = ADDR_W - 2;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_clr_cnt;
  logic               r_misalign;

  logic [IDX_W-1:0]   w_ri_idx;
  logic [IDX_W-1:0]   w_rd_idx;
  logic [IDX_W-1:0]   w_wd_idx;
  logic [IDX_W-1:0]   w_ld_idx;
  logic               w_run;
  logic               w_mis_now;
  logic               w_dm_we;
  logic [IDX_W-1:0]   w_dm_waddr;
  logic [DATA_W-1:0]  w_dm_wdata;
  logic               w_im_we;

  assign w_ri_idx = IDX_W'(word_index(32'(RAddr_i)));
  assign w_rd_idx = IDX_W'(word_index(32'(RAddr_d)));
  assign w_wd_idx = IDX_W'(word_index(32'(WAddr_d)));
  assign w_ld_idx = IDX_W'(word_index(32'(ld_addr)));

  assign w_run     = (r_state == RUN);
  assign w_mis_now = (|RAddr_i[1:0]) | (|RAddr_d[1:0]) | (Wen & (|WAddr_d[1:0]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= CLEAR;
    else     r_state <= w_state_nxt;
  end

  // While busy the dmem write port belongs to the clear sweep, so core Wen is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_dm_we     = 1'b0;
    w_dm_waddr  = w_wd_idx;
    w_dm_wdata  = Wdata_d;
    w_im_we     = 1'b0;
    ld_ready    = 1'b0;
    busy        = 1'b1;
    case (r_state)
      CLEAR: begin
        w_dm_we    = 1'b1;
        w_dm_waddr = r_clr_cnt;
        w_dm_wdata = CLEAR_VAL;
        if (r_clr_cnt == IDX_W'(DEPTH - 1)) w_state_nxt = LOAD;
      end
      LOAD: begin
        ld_ready = 1'b1;
        w_im_we  = ld_valid;
        if (ld_done) w_state_nxt = RUN;
      end
      RUN: begin
        busy    = 1'b0;
        w_dm_we = Wen;
      end
      default: w_state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   r_clr_cnt <= '0;
    else if (r_state == CLEAR) r_clr_cnt <= r_clr_cnt + IDX_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   r_misalign <= 1'b0;
    else if (w_run && w_mis_now) r_misalign <= 1'b1;
  end

  assign misalign = r_misalign;

  pipe_mem_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_imem (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_im_we),
    .i_waddr (w_ld_idx),
    .i_wdata (ld_data),
    .i_rd_en (w_run),
    .i_raddr (w_ri_idx),
    .o_rdata (Rdata_i)
  );

  pipe_mem_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_dmem (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_dm_we),
    .i_waddr (w_dm_waddr),
    .i_wdata (w_dm_wdata),
    .i_rd_en (w_run),
    .i_raddr (w_rd_idx),
    .o_rdata (Rdata_d)
  );

  // The core halts on the all-ones opcode, so it must never appear before RUN.
  a_no_finish_while_busy: assert property (@(posedge clk) disable iff (rst)
    busy |=> (Rdata_i[DATA_W-1 -: 6] != FINISH_OPCODE));

endmodule

// File: tb/tb_pipe_mem_responder.sv
// tb/tb_pipe_mem_responder.sv - table-driven scoreboard bench for pipe_mem_responder
module tb_pipe_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  RAddr_i = '0;
  logic [31:0] Rdata_i;
  logic [9:0]  RAddr_d = '0;
  logic [31:0] Rdata_d;
  logic        Wen = 1'b0;
  logic [9:0]  WAddr_d = '0;
  logic [31:0] Wdata_d = '0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [9:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic        ld_done = 1'b0;
  logic        busy;
  logic        misalign;

`ifdef PIPE_MEM_WR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  pipe_mem_responder dut (
    .clk      (clk),
    .rst      (rst),
    .RAddr_i  (RAddr_i),
    .Rdata_i  (Rdata_i),
    .RAddr_d  (RAddr_d),
    .Rdata_d  (Rdata_d),
    .Wen      (Wen),
    .WAddr_d  (WAddr_d),
    .Wdata_d  (Wdata_d),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .ld_done  (ld_done),
    .busy     (busy),
    .misalign (misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  ri;
    logic [9:0]  rd;
    logic        wen;
    logic [9:0]  wa;
    logic [31:0] wd;
    logic [31:0] exp_i;
    logic [31:0] exp_d;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    logic [31:0] ri;
    logic [31:0] rd;
    logic        mis;
  } exp_t;

  int          checks   = 0;
  int          failures = 0;
  exp_t        sb[$];
  vec_t        vecs[9];
  logic [31:0] prog[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic count_clear(output int n);
    n = 0;
    while (ld_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    exp_t e;
    RAddr_i = v.ri;
    RAddr_d = v.rd;
    Wen     = v.wen;
    WAddr_d = v.wa;
    Wdata_d = v.wd;
    sb.push_back('{ri: v.exp_i, rd: v.exp_d, mis: v.exp_mis});
    @(negedge clk);
    e = sb.pop_front();
    chk({nm, "_Rdata_i"}, Rdata_i, e.ri);
    chk({nm, "_Rdata_d"}, Rdata_d, e.rd);
    chk({nm, "_misalign"}, {31'b0, misalign}, {31'b0, e.mis});
  endtask

  initial begin
    int   n;
    vec_t v;

    prog = '{32'h20010005, 32'h20020007, 32'h00221820, 32'hFC000000};
    vecs[0] = '{10'h000, 10'h000, 1'b0, 10'h000, 32'h0, 32'h20010005, 32'h0, 1'b0};
    vecs[1] = '{10'h004, 10'h004, 1'b0, 10'h000, 32'h0, 32'h20020007, 32'h0, 1'b0};
    vecs[2] = '{10'h008, 10'h3FC, 1'b0, 10'h000, 32'h0, 32'h00221820, 32'h0, 1'b0};
    vecs[3] = '{10'h00C, 10'h010, 1'b1, 10'h010, 32'hDEADBEEF, 32'hFC000000,
                (BYP ? 32'hDEADBEEF : 32'h0), 1'b0};
    vecs[4] = '{10'h000, 10'h010, 1'b0, 10'h000, 32'h0, 32'h20010005, 32'hDEADBEEF, 1'b0};
    vecs[5] = '{10'h004, 10'h000, 1'b1, 10'h3FC, 32'hA5A50001, 32'h20020007, 32'h0, 1'b0};
    vecs[6] = '{10'h008, 10'h3FC, 1'b0, 10'h000, 32'h0, 32'h00221820, 32'hA5A50001, 1'b0};
    vecs[7] = '{10'h00C, 10'h013, 1'b0, 10'h000, 32'h0, 32'hFC000000, 32'hDEADBEEF, 1'b1};
    vecs[8] = '{10'h000, 10'h000, 1'b0, 10'h000, 32'h0, 32'h20010005, 32'h0, 1'b1};

    repeat (2) @(negedge clk);
    chk("rst_Rdata_i", Rdata_i, 32'h0);
    chk("rst_Rdata_d", Rdata_d, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'd1);
    chk("rst_ld_ready", {31'b0, ld_ready}, 32'd0);
    chk("rst_misalign", {31'b0, misalign}, 32'd0);

    rst = 1'b0;
    count_clear(n);
    chk("clear_cycles_1", n, 256);
    chk("load_busy", {31'b0, busy}, 32'd1);

    for (int k = 0; k < 2; k++) begin
      ld_valid = 1'b1;
      ld_addr  = 10'(k * 4);
      ld_data  = prog[k];
      @(negedge clk);
    end
    ld_valid = 1'b0;

    // Async reset mid-cycle, well away from the next rising edge.
    #2 rst = 1'b1;
    #1;
    chk("midrst_ld_ready", {31'b0, ld_ready}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    Wen     = 1'b1;
    WAddr_d = 10'h004;
    Wdata_d = 32'h12345678;
    RAddr_d = 10'h004;
    RAddr_i = 10'h000;
    count_clear(n);
    chk("clear_cycles_2", n, 256);
    chk("clear_Rdata_d", Rdata_d, 32'h0);
    Wen = 1'b0;

    for (int k = 2; k < 4; k++) begin
      ld_valid = 1'b1;
      ld_addr  = 10'(k * 4);
      ld_data  = prog[k];
      ld_done  = (k == 3);
      @(negedge clk);
      chk("load_Rdata_i_nop", Rdata_i, 32'h0);
    end
    ld_done = 1'b0;
    chk("run_busy", {31'b0, busy}, 32'd0);
    chk("run_ld_ready", {31'b0, ld_ready}, 32'd0);

    // Loader beats in RUN must be ignored; imem[0] must keep its loaded word.
    ld_valid = 1'b1;
    ld_addr  = 10'h000;
    ld_data  = 32'hFFFFFFFF;
    for (int i = 0; i < 256; i++) begin
      v = '{10'h000, 10'(i * 4), 1'b0, 10'h000, 32'h0, prog[0], 32'h0, 1'b0};
      run_vec(v, "sweep");
    end
    ld_valid = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    #2 rst = 1'b1;
    #1;
    chk("final_rst_misalign", {31'b0, misalign}, 32'd0);
    chk("final_rst_Rdata_i", Rdata_i, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
